// File: rtl/uart_sim_rx.sv
// UART receiver for simulation/bring-up: 8N1 deserialiser with a 2-flop input
// synchroniser, mid-bit sampling driven by a 16-bit bit counter, and a
// first-word-fall-through receive FIFO with a sticky overflow flag.
module uart_sim_rx #(
  parameter int CLK_DIV = 868,  // system clocks per UART bit, 4..65535
  parameter int FIFO_AW = 4     // log2 of receive FIFO depth
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam int          DEPTH     = 1 << FIFO_AW;
  // Half a bit from the start edge lands the first sample mid start bit.
  localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] BIT_LOAD  = 16'(CLK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // Two flops bring the asynchronous line into the clock domain; reset to idle-high.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like the hardware.
    if (wb_rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        frame_err_d;
  logic        push;

  // State register plus the bit counter, bit index and shift register it steers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      frame_err_o <= frame_err_d;
    end
  end

  // Next-state logic: sample rx_s whenever the counter expires in a timed state.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which is what would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // IDLE is only ever entered with rx_s high, so a low here is a falling edge.
        if (!rx_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end

      START: begin
        if (cnt_q == 16'd0) begin
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = 3'd0;
            cnt_d   = BIT_LOAD;
          end else begin
            state_d = IDLE;  // start bit did not hold: glitch
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == 16'd0) begin
          shreg_d[idx_q] = rx_s;
          cnt_d          = BIT_LOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      STOP: begin
        if (cnt_q == 16'd0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;  // swallow a break until the line recovers
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, rd_ptr_d;
  logic             full;
  logic             pop;
  logic             do_write;

  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop      = valid_o && ready_i;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign do_write = push && (!full || pop);
  assign rd_ptr_d = pop ? rd_ptr + 1'b1 : rd_ptr;

  // Storage array written at the tail slot.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers alone, so resetting it would only cost flops.
    if (do_write) mem[wr_ptr[FIFO_AW-1:0]] <= shreg_q;
  end

  // Pointers, registered non-empty flag and sticky overflow.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_d;
      // Built from the pre-push write pointer: a new byte shows up one edge
      // after it is written, and a pop never sees a stale valid.
      valid_o <= (wr_ptr != rd_ptr_d);
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  end

  // Head of the FIFO, forced to zero whenever nothing is presented.
  assign data_o = valid_o ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;

endmodule
